// File: rtl/scp_pkg.sv
// ---------------------------------------------------------------------------
// scp_pkg
//   Shared definitions for the scalar core pipeline: register-file geometry
//   and the write-back entry type (destination register + result value).
//   The write-back queue and its forwarding matcher take their default
//   widths from this package.
//   Optional feature macro used by wb_queue: WBQ_FORWARD_EN.
// ---------------------------------------------------------------------------
package scp_pkg;

  localparam int REG_BITS  = 4;   // 16 architectural registers
  localparam int DATA_BITS = 32;  // register file width

  // One pending write-back. The destination field cannot be called "reg"
  // because that is a reserved word, hence reg_idx.
  typedef struct packed {
    logic [REG_BITS-1:0]  reg_idx;
    logic [DATA_BITS-1:0] data;
  } wb_entry_t;

endpackage : scp_pkg

// File: rtl/wbq_fwd_match.sv
// ---------------------------------------------------------------------------
// wbq_fwd_match
//   Forwarding lookup for one read port of the write-back queue. Scans all
//   entries in age order starting at the head and reports the youngest valid
//   entry whose destination matches the requested source index.
//
//   Ports:
//     ent_reg_i   [DEPTH][RBITS]  destination register of every slot
//     ent_data_i  [DEPTH][DBITS]  data of every slot
//     valid_i     [DEPTH]         slot holds a pending (not yet drained) entry
//     head_idx_i  [AW]            slot index of the oldest entry
//     rs_i        [RBITS]         source register being read
//     hit_o                       a pending value exists for rs_i
//     data_o      [DBITS]         youngest pending value, 0 when no hit
// ---------------------------------------------------------------------------
module wbq_fwd_match
  import scp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RBITS = REG_BITS,
  parameter int DBITS = DATA_BITS
) (
  input  logic [DEPTH-1:0][RBITS-1:0] ent_reg_i,
  input  logic [DEPTH-1:0][DBITS-1:0] ent_data_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [$clog2(DEPTH)-1:0]    head_idx_i,
  input  logic [RBITS-1:0]            rs_i,
  output logic                        hit_o,
  output logic [DBITS-1:0]            data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the result is the entry nearest to the tail.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx_i + AW'(k);
      if (valid_i[idx] && (ent_reg_i[idx] == rs_i)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule : wbq_fwd_match

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue
//   In-order write-back queue in front of the register file's single write
//   port. Producers push (register, value) pairs through a valid/ready
//   handshake; the head entry is presented to the register file and retired
//   on every cycle the write port is granted. An optional forwarding lookup
//   exposes values still pending in the queue to the read stage.
//
//   Configuration macro: WBQ_FORWARD_EN
//     defined   - two wbq_fwd_match instances drive fwd1_*/fwd2_*
//     undefined - forwarding outputs are tied to 0, RS1/RS2 are ignored
//
//   Ports:
//     CLK, RESET          clock, synchronous active-high reset
//     push_valid/ready    producer handshake (ready = !full)
//     push_reg/push_data  entry being offered
//     drain_en            register file write port granted this cycle
//     WrEn/RD/wr_data     register file write port (head entry)
//     count               current occupancy, 0..DEPTH
//     RS1/RS2             read-stage source indices
//     fwd1_*/fwd2_*       forwarding hit and youngest pending value
// ---------------------------------------------------------------------------
module wb_queue
  import scp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DBITS = DATA_BITS,
  parameter int RBITS = REG_BITS
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [RBITS-1:0]           push_reg,
  input  logic [DBITS-1:0]           push_data,
  input  logic                       drain_en,
  output logic                       WrEn,
  output logic [RBITS-1:0]           RD,
  output logic [DBITS-1:0]           wr_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [RBITS-1:0]           RS1,
  input  logic [RBITS-1:0]           RS2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [DBITS-1:0]           fwd1_data,
  output logic [DBITS-1:0]           fwd2_data
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] head_q, head_d;
  logic [AW:0] tail_q, tail_d;

  // Entry storage is plain flops: the forwarding scan needs every slot in
  // parallel, so a RAM with a single read port would not do.
  logic [DEPTH-1:0][RBITS-1:0] reg_mem_q;
  logic [DEPTH-1:0][DBITS-1:0] data_mem_q;

  logic [AW-1:0] head_idx, tail_idx;
  logic          empty, full;
  logic          push_fire, pop_fire;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);

  // Pointer difference modulo 2*DEPTH is the occupancy.
  assign count = tail_q - head_q;

  // push_ready depends on state only, never on drain_en, so a full queue
  // refuses a push even in a cycle where it also drains.
  assign push_ready = !full;
  assign push_fire  = push_valid && push_ready;

  // Reset suppresses the write so entries being discarded never reach the
  // register file.
  assign WrEn     = !empty && drain_en && !RESET;
  assign pop_fire = WrEn;
  assign RD       = reg_mem_q[head_idx];
  assign wr_data  = data_mem_q[head_idx];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_fire)  head_d = head_q + 1'b1;
    if (push_fire) tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Contents are not reset; only the pointers define which slots are live.
  always_ff @(posedge CLK) begin
    if (push_fire) begin
      reg_mem_q[tail_idx]  <= push_reg;
      data_mem_q[tail_idx] <= push_data;
    end
  end

`ifdef WBQ_FORWARD_EN
  logic [DEPTH-1:0] valid_mask;

  // Slot gi is live when its distance from the head is below the occupancy.
  // An entry popped this cycle is still live here; a pushed one is not yet.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [AW-1:0] dist;
    assign dist           = AW'(gi) - head_idx;
    assign valid_mask[gi] = ({1'b0, dist} < count);
  end

  wbq_fwd_match #(
    .DEPTH (DEPTH),
    .RBITS (RBITS),
    .DBITS (DBITS)
  ) u_fwd1 (
    .ent_reg_i  (reg_mem_q),
    .ent_data_i (data_mem_q),
    .valid_i    (valid_mask),
    .head_idx_i (head_idx),
    .rs_i       (RS1),
    .hit_o      (fwd1_hit),
    .data_o     (fwd1_data)
  );

  wbq_fwd_match #(
    .DEPTH (DEPTH),
    .RBITS (RBITS),
    .DBITS (DBITS)
  ) u_fwd2 (
    .ent_reg_i  (reg_mem_q),
    .ent_data_i (data_mem_q),
    .valid_i    (valid_mask),
    .head_idx_i (head_idx),
    .rs_i       (RS2),
    .hit_o      (fwd2_hit),
    .data_o     (fwd2_data)
  );
`else
  // Read indices are kept on the interface but have no function here.
  logic unused_rs;
  assign unused_rs = ^{RS1, RS2};

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule : wb_queue

// File: tb/tb_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_queue
//   Self-checking bench for wb_queue. A queue of pending entries models the
//   expected contents; every cycle the DUT outputs are compared against it
//   before the clock edge and the model is advanced afterwards.
// ---------------------------------------------------------------------------
module tb_wb_queue;
  import scp_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 push_valid;
  logic                 push_ready;
  logic [REG_BITS-1:0]  push_reg;
  logic [DATA_BITS-1:0] push_data;
  logic                 drain_en;
  logic                 WrEn;
  logic [REG_BITS-1:0]  RD;
  logic [DATA_BITS-1:0] wr_data;
  logic [CW-1:0]        count;
  logic [REG_BITS-1:0]  RS1, RS2;
  logic                 fwd1_hit, fwd2_hit;
  logic [DATA_BITS-1:0] fwd1_data, fwd2_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  wb_entry_t model_q[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_reg   (push_reg),
    .push_data  (push_data),
    .drain_en   (drain_en),
    .WrEn       (WrEn),
    .RD         (RD),
    .wr_data    (wr_data),
    .count      (count),
    .RS1        (RS1),
    .RS2        (RS2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Youngest pending value for a register, from the model contents.
  task automatic model_fwd(input logic [REG_BITS-1:0] rs, output logic hit,
                           output logic [DATA_BITS-1:0] val);
    hit = 1'b0;
    val = '0;
    if (FWD) begin
      foreach (model_q[i]) begin
        if (model_q[i].reg_idx == rs) begin
          hit = 1'b1;
          val = model_q[i].data;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, take the
  // edge, then update the model with what should have happened.
  task automatic cycle(input logic rst, input logic pv, input logic [REG_BITS-1:0] preg,
                       input logic [DATA_BITS-1:0] pdata, input logic de,
                       input logic [REG_BITS-1:0] r1, input logic [REG_BITS-1:0] r2);
    logic                 e_ready, e_wren, h1, h2;
    logic [DATA_BITS-1:0] d1, d2;
    wb_entry_t            ent;
    RESET      = rst;
    push_valid = pv;
    push_reg   = preg;
    push_data  = pdata;
    drain_en   = de;
    RS1        = r1;
    RS2        = r2;
    #2;
    e_ready = (model_q.size() < DEPTH);
    e_wren  = (model_q.size() > 0) && de && !rst;
    chk("count", 64'(count), 64'(model_q.size()));
    chk("push_ready", 64'(push_ready), 64'(e_ready));
    chk("WrEn", 64'(WrEn), 64'(e_wren));
    if (e_wren) begin
      chk("RD", 64'(RD), 64'(model_q[0].reg_idx));
      chk("wr_data", 64'(wr_data), 64'(model_q[0].data));
    end
    model_fwd(r1, h1, d1);
    model_fwd(r2, h2, d2);
    chk("fwd1_hit", 64'(fwd1_hit), 64'(h1));
    chk("fwd1_data", 64'(fwd1_data), 64'(d1));
    chk("fwd2_hit", 64'(fwd2_hit), 64'(h2));
    chk("fwd2_data", 64'(fwd2_data), 64'(d2));
    $display("cyc %0d rst=%0b push=%0b(r%0d,%0h) acc=%0b wr=%0b(r%0d,%0h) cnt=%0d",
             cyc, rst, pv, preg, pdata, pv && e_ready, WrEn, RD, wr_data, count);
    @(posedge CLK);
    cyc++;
    if (rst) begin
      model_q.delete();
    end else begin
      if (e_wren) void'(model_q.pop_front());
      if (pv && e_ready) begin
        ent.reg_idx = preg;
        ent.data    = pdata;
        model_q.push_back(ent);
      end
    end
    #1;
  endtask

  initial begin
    RESET = 1'b1; push_valid = 1'b0; push_reg = '0; push_data = '0;
    drain_en = 1'b0; RS1 = '0; RS2 = '0;
    @(posedge CLK); #1;

    // Reset with the write port granted: nothing written, queue empty.
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(push_ready), 64'd1);
    chk("rst_fwd1", 64'(fwd1_hit), 64'd0);

    // Single push drained on the next edge.
    cycle(0, 1, 3, 3, 1, 0, 0);
    #2;
    chk("p1_wren", 64'(WrEn), 64'd1);
    chk("p1_rd", 64'(RD), 64'd3);
    chk("p1_data", 64'(wr_data), 64'd3);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);

    // Fill with the port held off, then a refused fifth push.
    cycle(0, 1, 1, 1, 0, 0, 0);
    cycle(0, 1, 2, 2, 0, 0, 0);
    cycle(0, 1, 4, 5, 0, 0, 0);
    cycle(0, 1, 5, 8, 0, 0, 0);
    #2;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(push_ready), 64'd0);
    cycle(0, 1, 9, 32'h99, 0, 0, 0);
    // Full with push and drain together: only the pop happens.
    cycle(0, 1, 9, 32'h99, 1, 0, 0);
    #2;
    chk("fp_count", 64'(count), 64'd3);
    chk("fp_ready", 64'(push_ready), 64'd1);
    cycle(0, 1, 10, 32'haa, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0);

    // Two writes to the same register: youngest forwarded, both drained.
    cycle(0, 1, 6, 13, 0, 6, 7);
    cycle(0, 1, 6, 21, 0, 6, 7);
    cycle(0, 0, 0, 0, 0, 6, 7);
    #2;
    chk("fw_hit1", 64'(fwd1_hit), 64'(FWD));
    chk("fw_data1", 64'(fwd1_data), FWD ? 64'd21 : 64'd0);
    chk("fw_hit2", 64'(fwd2_hit), 64'd0);
    cycle(0, 0, 0, 0, 1, 6, 7);
    #2;
    chk("fw_rd2", 64'(RD), 64'd6);
    chk("fw_wd2", 64'(wr_data), 64'd21);
    cycle(0, 0, 0, 0, 1, 6, 7);
    cycle(0, 0, 0, 0, 1, 6, 7);

    // Reset in the middle of operation discards pending entries.
    cycle(0, 1, 7, 32'h70, 0, 7, 0);
    cycle(0, 1, 8, 32'h80, 0, 7, 0);
    cycle(0, 1, 9, 32'h90, 0, 7, 0);
    cycle(1, 0, 0, 0, 1, 7, 0);
    #2;
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_ready", 64'(push_ready), 64'd1);
    chk("mr_wren", 64'(WrEn), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 7, 8);

    // Randomized traffic with occasional resets; small register range so
    // forwarding hits and same-register repeats are common.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)),
            REG_BITS'($urandom_range(0, 3)),
            $urandom(),
            ($urandom_range(0, 2) != 0),
            REG_BITS'($urandom_range(0, 4)),
            REG_BITS'($urandom_range(0, 4)));
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_queue

// File: doc/wb_queue.md
# wb_queue

Write-back queue in front of the register file's single write port. Accepts completed results (destination register plus 32-bit value) from execution units through a valid/ready handshake, buffers them in order, and drains one entry per cycle into the register file via `WrEn`/`RD`/`in`. An optional forwarding lookup lets the read stage see values still pending in the queue.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, ≥2.
- `DBITS`, default 32: data width; matches register file width.
- `RBITS`, default 4: register index width (16 registers).

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  producer presents a result.
- `push_ready`  out  1  queue can accept; equals `!full`, with no combinational dependence on `drain_en`.
- `push_reg`  in  RBITS  destination register.
- `push_data`  in  DBITS  result value.
- `drain_en`  in  1  register file write port granted this cycle.
- `WrEn`  out  1  write enable to the register file.
- `RD`  out  RBITS  write address to the register file.
- `wr_data`  out  DBITS  write data; connects to the register file `in`.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `RS1`, `RS2`  in  RBITS  read-stage source indices, for forwarding.
- `fwd1_hit`, `fwd2_hit`  out  1  pending value exists for `RS1`/`RS2`.
- `fwd1_data`, `fwd2_data`  out  DBITS  youngest pending value for `RS1`/`RS2`.

## Operation
- Circular buffer with `head`/`tail` pointers of log2(DEPTH) bits plus one wrap bit each.
- Empty when the pointers are equal including the wrap bit. Full when the indices are equal and the wrap bits differ.
- A push fires when `push_valid && push_ready`. It writes the tail entry and increments `tail`; the pointer wraps modulo DEPTH and toggles its wrap bit.
- Head outputs are combinational from the head entry:
  - `WrEn = !empty && drain_en`
  - `RD` = head register
  - `wr_data` = head data
- A pop fires when `WrEn` is high; `head` increments at the same edge the register file commits the write.
- Simultaneous push and pop: both occur and `count` is unchanged.
- Simultaneous push and pop when full: the push is refused (`push_ready` is 0) and the pop proceeds; the queue accepts again the next cycle.
- Writes are strictly in push order. Repeated writes to the same register are all drained; none are coalesced.
- No filtering by register index: writes to r0 are drained like any other.
- `drain_en` low: the queue holds and `WrEn` is 0; pushes continue until full.
- `RESET`:
  - pointers go to 0, so `count`=0, `WrEn`=0 and `push_ready`=1.
  - entry contents are not cleared; `RD`/`wr_data` are don't-care while empty.
  - `fwd*_hit`=0.
- Reset asserted mid-operation discards all pending entries, with no register file write in that cycle.

## Timing
- Push accepted at edge N: the entry is head-visible after edge N if the queue was empty. With `drain_en`=1 it is committed to the register file at edge N+1.
- Minimum push-to-RF latency is 1 cycle; sustained throughput is 1 entry/cycle.
- `count` updates at the edge following push/pop.
- Forwarding outputs are combinational from `RS1`/`RS2` and the current valid entries.
  - An entry being popped this cycle still counts as a hit.
  - An entry being pushed this cycle is not a hit until the next cycle.

## Configuration
- `WBQ_FORWARD_EN` defined: forwarding logic is present.
  - Each port scans all valid entries and reports the youngest match (nearest to `tail`).
  - `fwd*_data` equals that entry's data; 0 when there is no hit.
- Not defined: `fwd1_hit`, `fwd2_hit`, `fwd1_data` and `fwd2_data` are tied to 0. `RS1`/`RS2` are unused; the ports remain.

## Structure
- Shared package `scp_pkg`: `REG_BITS`=4, `DATA_BITS`=32, and the `wb_entry_t` struct {reg, data}.
- Sub-module `wbq_fwd_match`: one instance per read port; takes the entry array, the valid mask, the head pointer and the index, and returns hit/data with youngest priority.
- All other logic lives in `wb_queue`.

## Test plan
- Reset, then push (r3, 3) with `drain_en`=1 → next cycle `WrEn`=1, `RD`=3, `wr_data`=3; `count` returns to 0.
- `drain_en`=0, push (r1, 1), (r2, 2), (r4, 5), (r5, 8) → `count`=4, `push_ready`=0; fifth push refused; on `drain_en`=1, writes r1, r2, r4, r5 in order on 4 consecutive edges.
- Full queue, `push_valid` and `drain_en` high for 1 cycle → one pop, no push, `count`=3; next cycle push accepted.
- Push (r6, 13) then (r6, 21) with `drain_en`=0, `RS1`=6 (`WBQ_FORWARD_EN`) → `fwd1_hit`=1, `fwd1_data`=21; `RS2`=7 → `fwd2_hit`=0.
- Same stimulus without the macro → `fwd1_hit`=0 and `fwd1_data`=0; drain still writes 13 then 21 to r6.
- Push 3 entries, assert `RESET` for 1 cycle with `drain_en`=1 → `WrEn`=0 that cycle; `count`=0 and `push_ready`=1 after the edge; no stale writes afterwards.
